// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN PE grid: loads one weight tile, then streams
// skewed activation rows into the array's left edge.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   num_rows,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*DW-1:0] a_data,
  output logic [N*DW-1:0] pe_win,
  output logic            pe_wwrite,
  output logic [N*DW-1:0] pe_datain,
  output logic            pe_active,
  output logic            busy,
  output logic            done
);

  localparam int LW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WPUSH,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [N*DW-1:0] wbuf [N];
  logic [LW-1:0]   widx;
  logic [LW-1:0]   pk;
  logic [DCW-1:0]  dc;
  logic [CW-1:0]   nrows;
  logic [CW-1:0]   cnt;
  logic            a_acc;
  logic            adv;

  assign w_ready = (state == S_WLOAD);
  assign a_ready = (state == S_STREAM);
  assign busy    = (state != S_IDLE);
  assign a_acc   = a_valid & a_ready;
  assign adv     = a_acc | (state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      widx      <= '0;
      pk        <= '0;
      dc        <= '0;
      cnt       <= '0;
      nrows     <= '0;
      pe_win    <= '0;
      pe_wwrite <= 1'b0;
      pe_active <= 1'b0;
      done      <= 1'b0;
      for (int r = 0; r < N; r++) wbuf[r] <= '0;
    end else begin
      done      <= 1'b0;
      pe_active <= adv;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nrows <= num_rows;
            widx  <= '0;
            state <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (w_valid) begin
            wbuf[widx] <= w_data;
            widx       <= widx + 1'b1;
            // bottom row goes out first, straight from the bus
            if (widx == LW'(N - 1)) begin
              state     <= S_WPUSH;
              pk        <= '0;
              pe_wwrite <= 1'b1;
              pe_win    <= w_data;
            end
          end
        end
        S_WPUSH: begin
          pk <= pk + 1'b1;
          if (pk == LW'(N - 1)) begin
            pe_wwrite <= 1'b0;
            pe_win    <= '0;
            cnt       <= '0;
            if (nrows == '0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_STREAM;
            end
          end else begin
            pe_win <= wbuf[LW'(N - 2) - pk];
          end
        end
        S_STREAM: begin
          if (a_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == nrows - 1'b1) begin
              dc    <= '0;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          dc <= dc + 1'b1;
          if (dc == DCW'(2 * N - 2)) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] pipe [i+1];
    logic [DW-1:0] lin;

    assign lin = (state == S_STREAM) ? a_data[i*DW +: DW] : '0;

    // lane i is delayed by i extra advance steps
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) pipe[k] <= '0;
      end else if (adv) begin
        pipe[0] <= lin;
        for (int k = 1; k <= i; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign pe_datain[i*DW +: DW] = pipe[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: directed tiles, queued
// expectations, negedge monitor.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_rows = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [VW-1:0] w_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [VW-1:0] a_data = '0;
  logic [VW-1:0] pe_win;
  logic          pe_wwrite;
  logic [VW-1:0] pe_datain;
  logic          pe_active;
  logic          busy;
  logic          done;

  systolic_feeder #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_win(pe_win), .pe_wwrite(pe_wwrite), .pe_datain(pe_datain),
    .pe_active(pe_active), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] wq [$];
  logic [VW-1:0] dq [$];
  int            doneq [$];
  int            beats = 0;
  logic [VW-1:0] prev = '0;
  int            nvec = 0;
  int            nmis = 0;
  logic [VW-1:0] arow [3];

  task automatic check(input string nm, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  function automatic logic [VW-1:0] pack(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev = pe_datain;
    end else begin
      if (pe_wwrite) begin
        if (wq.size() == 0) fail("pe_win_extra");
        else check("pe_win", pe_win, wq.pop_front());
      end else begin
        check("pe_win_idle", pe_win, '0);
      end
      if (pe_active) begin
        beats++;
        if (dq.size() == 0) fail("pe_datain_extra");
        else check("pe_datain", pe_datain, dq.pop_front());
      end else begin
        check("pe_datain_hold", pe_datain, prev);
      end
      prev = pe_datain;
      if (done) begin
        if (doneq.size() == 0) fail("done_extra");
        else check("done_beats", VW'(beats), VW'(doneq.pop_front()));
        beats = 0;
      end
    end
  end

  task automatic send_w(input logic [VW-1:0] d);
    int cyc = 0;
    w_valid = 1'b1;
    w_data  = d;
    @(negedge clk);
    while (!w_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!w_ready) fail("w_ready_timeout");
    @(posedge clk);
    #1;
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [VW-1:0] d);
    int cyc = 0;
    a_valid = 1'b1;
    a_data  = d;
    @(negedge clk);
    while (!a_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!a_ready) fail("a_ready_timeout");
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_win"}, pe_win, '0);
    check({nm, "_datain"}, pe_datain, '0);
    check({nm, "_ctrl"},
          VW'({busy, done, pe_active, pe_wwrite, w_ready, a_ready}), '0);
  endtask

  task automatic run_tile(input int nr, input int abort_after,
                          input int gap_at, input bit poke);
    logic [VW-1:0] wrow [N];
    logic [VW-1:0] v;
    int            idx;
    int            cyc;
    bit            saw_ar;
    for (int r = 0; r < N; r++)
      wrow[r] = pack(8'(r*4), 8'(r*4+1), 8'(r*4+2), 8'(r*4+3));
    for (int r = N - 1; r >= 0; r--) wq.push_back(wrow[r]);
    if (nr > 0) begin
      for (int k = 1; k <= nr + 2*N - 1; k++) begin
        v = '0;
        for (int i = 0; i < N; i++) begin
          idx = k - i;
          if (idx >= 1 && idx <= nr) v[i*DW +: DW] = arow[idx-1][i*DW +: DW];
        end
        dq.push_back(v);
      end
    end
    if (abort_after < 0) doneq.push_back(nr == 0 ? 0 : nr + 2*N - 1);
    start    = 1'b1;
    num_rows = CW'(nr);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int r = 0; r < N; r++) send_w(wrow[r]);
    if (poke) begin
      start   = 1'b1;
      w_valid = 1'b1;
      w_data  = '1;
    end
    for (int j = 0; j < nr; j++) begin
      if (j == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        wq.delete();
        dq.delete();
        beats = 0;
        @(posedge clk);
        #1;
        check_reset_outputs("abort_edge");
        rst = 1'b0;
        return;
      end
      if (j == gap_at) repeat (2) begin
        @(posedge clk);
        #1;
      end
      send_a(arow[j]);
      if (j == 0) check("busy_stream", VW'(busy), VW'(1));
      if (poke && j == 0) begin
        check("w_ready_stream", VW'(w_ready), '0);
        start   = 1'b0;
        w_valid = 1'b0;
      end
    end
    cyc    = 0;
    saw_ar = 1'b0;
    @(negedge clk);
    while (!done && cyc < 100) begin
      saw_ar |= a_ready;
      @(negedge clk);
      cyc++;
    end
    if (!done) fail("done_timeout");
    else check("busy_at_done", VW'(busy), '0);
    if (nr == 0) check("a_ready_never", VW'(saw_ar), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    arow[0] = pack(8'h7f, 8'h80, 8'hff, 8'h01);
    arow[1] = pack(8'h10, 8'h20, 8'h30, 8'h40);
    arow[2] = pack(8'hfe, 8'h05, 8'h81, 8'h7e);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_tile(3, 2, -1, 1'b0);
    run_tile(3, -1, -1, 1'b0);
    run_tile(3, -1, 1, 1'b0);
    run_tile(0, -1, -1, 1'b0);
    run_tile(3, -1, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("wq_drained", VW'(wq.size()), '0);
    check("dq_drained", VW'(dq.size()), '0);
    check("doneq_drained", VW'(doneq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
